alu_iterative: RTL

ALU_ITERATIVE -- requirements
Module: alu_iterative

---
 rtl/alu_iterative.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/alu_iterative.sv
// Iterative ALU: logic/add/sub/slt complete in one cycle; multiply and divide
// run WIDTH radix-2 steps (shift-add / restoring) before the result registers.
module alu_iterative #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] ALU_in_X,
    input  logic [WIDTH-1:0] ALU_in_Y,
    output logic [WIDTH-1:0] ALU_out_S,
    output logic             ZR,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [1:0]           op_q, op_d;
    logic [WIDTH-1:0]     x_q, x_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     s_q, s_d;
    logic                 zr_q, zr_d;

    logic                 slt_lt;
    logic [WIDTH-1:0]     single_res;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_sub;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   step_next;
    logic [WIDTH-1:0]     iter_res;

    assign slt_lt = $signed(ALU_in_X) < $signed(ALU_in_Y);

    always_comb begin
        single_res = '0;
        case (operation)
            4'b0000: single_res = ALU_in_X & ALU_in_Y;
            4'b0001: single_res = ALU_in_X | ALU_in_Y;
            4'b0010: single_res = ALU_in_X + ALU_in_Y;
            4'b0110: single_res = ALU_in_X - ALU_in_Y;
            4'b0111: single_res = {{(WIDTH-1){1'b0}}, slt_lt};
            4'b1100: single_res = ~(ALU_in_X | ALU_in_Y);
            default: single_res = '0;
        endcase
    end

    // acc_q holds {hi, lo}: multiply = {partial product, multiplier},
    // divide = {remainder, dividend shifting into quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + {1'b0, (acc_q[0] ? x_q : {WIDTH{1'b0}})};
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, x_q};
        div_sub   = WIDTH'(div_shift - {1'b0, x_q});
        div_next  = div_ge ? {div_sub, acc_q[WIDTH-2:0], 1'b1}
                           : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        step_next = op_q[1] ? div_next : mul_next;
        iter_res  = op_q[0] ? step_next[2*WIDTH-1:WIDTH] : step_next[WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        x_d     = x_q;
        acc_d   = acc_q;
        s_d     = s_q;
        zr_d    = zr_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    op_d = operation[1:0];
                    if (operation[3:2] == 2'b10) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        // Divide keeps the divisor in x_q; multiply the multiplicand.
                        if (operation[1]) begin
                            x_d   = ALU_in_Y;
                            acc_d = {{WIDTH{1'b0}}, ALU_in_X};
                        end else begin
                            x_d   = ALU_in_X;
                            acc_d = {{WIDTH{1'b0}}, ALU_in_Y};
                        end
                    end else begin
                        state_d = DONE;
                        s_d     = single_res;
                        zr_d    = (single_res == '0);
                    end
                end
            end
            RUN: begin
                acc_d = step_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    s_d     = iter_res;
                    zr_d    = (iter_res == '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            x_q     <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            zr_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            x_q     <= x_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            zr_q    <= zr_d;
        end
    end

    assign ALU_out_S = s_q;
    assign ZR        = zr_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);

endmodule
